// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_pkg
// Description : Shared types for the instruction fetch unit and its cache.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL0 = 2'd1,
    ST_FILL1 = 2'd2
  } fetch_state_t;

  // One cache line: an even/odd word pair.
  typedef struct packed {
    word_t w1;
    word_t w0;
  } line_t;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Direct-mapped tag/valid/data store, async read, sync line write.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_array
  import mips_fetch_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_W - 1 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output line_t            o_rd_line,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  line_t            i_wr_line
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  line_t            r_data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Paired-word instruction fetch with a direct-mapped line cache.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          LINES    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        hit,
  output logic [15:0] instruction,
  output logic [15:0] nextinstruction,
  output logic [15:0] pc
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 1 - IDX_W;

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  addr_t            r_pc;
  word_t            r_word0;
  logic             w_capture;
  logic             w_wr_en;
  logic             w_lookup_hit;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  line_t            w_rd_line;
  line_t            w_wr_line;

  assign w_idx        = r_pc[IDX_W:1];
  assign w_tag        = r_pc[ADDR_W-1:IDX_W+1];
  assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);
  assign w_wr_line    = '{w1: mem_rdata, w0: r_word0};

  icache_array #(
    .LINES (LINES)
  ) u_icache_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_line  (w_rd_line),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_idx),
    .i_wr_tag   (w_tag),
    .i_wr_line  (w_wr_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A FILL1 beat accepted together with redirect still commits the line.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_addr     = '0;
    w_capture    = 1'b0;
    w_wr_en      = 1'b0;
    hit          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        hit = w_lookup_hit;
        if (!redirect && !w_lookup_hit) begin
          w_next_state = ST_FILL0;
        end
      end
      ST_FILL0: begin
        mem_req  = 1'b1;
        mem_addr = {r_pc[ADDR_W-1:1], 1'b0};
        if (redirect) begin
          w_next_state = ST_IDLE;
        end else if (mem_ready) begin
          w_capture    = 1'b1;
          w_next_state = ST_FILL1;
        end
      end
      ST_FILL1: begin
        mem_req  = 1'b1;
        mem_addr = {r_pc[ADDR_W-1:1], 1'b1};
        if (mem_ready) begin
          w_wr_en      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (redirect) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= redirect_pc & 16'hFFFE;
    end else if (hit && !stall) begin
      r_pc <= r_pc + 16'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word0 <= '0;
    end else if (w_capture) begin
      r_word0 <= mem_rdata;
    end
  end

  assign pc              = r_pc;
  assign instruction     = w_rd_line.w0;
  assign nextinstruction = w_rd_line.w1;

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 16'h0000, word address loaded into pc on reset (bit 0 SHALL be 0).
REQ-002: Parameter LINES, default 8, number of direct-mapped cache lines (power of two, 2..64).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: stall  input  1  downstream cannot accept a pair; hold pc.
REQ-006: redirect  input  1  branch/jump taken; load redirect_pc.
REQ-007: redirect_pc  input  16  target word address; bit 0 ignored.
REQ-008: mem_req  output  1  fill request to instruction memory.
REQ-009: mem_addr  output  16  word address of current fill beat.
REQ-010: mem_ready  input  1  memory accepts the beat; mem_rdata valid this cycle.
REQ-011: mem_rdata  input  16  fill data word.
REQ-012: hit  output  1  instruction/nextinstruction valid this cycle.
REQ-013: instruction  output  16  word at pc.
REQ-014: nextinstruction  output  16  word at pc+1.
REQ-015: pc  output  16  current fetch word address, always even.

Function
REQ-016: Line = two 16-bit words; index = pc[log2(LINES):1], tag = pc[15:log2(LINES)+1], one valid bit per line.
REQ-017: FSM states: IDLE, FILL0, FILL1.
REQ-018: In IDLE, hit SHALL be combinationally 1 iff valid[index] and stored tag equals pc tag; instruction/nextinstruction = line words 0/1.
REQ-019: hit SHALL be 0 in FILL0 and FILL1; instruction/nextinstruction are don't-care when hit=0.
REQ-020: IDLE, hit=1, stall=0, redirect=0: pc <= pc+2 next edge (16-bit wrap, 16'hFFFE -> 16'h0000).
REQ-021: IDLE, hit=1, stall=1, redirect=0: pc and outputs held unchanged.
REQ-022: IDLE, hit=0, redirect=0: next state FILL0 (one-cycle miss detection latency).
REQ-023: FILL0: mem_req=1, mem_addr={pc[15:1],1'b0}; on mem_ready capture mem_rdata as word 0, go FILL1.
REQ-024: FILL1: mem_req=1, mem_addr={pc[15:1],1'b1}; on mem_ready write both words, tag, valid=1 into line, go IDLE.
REQ-025: mem_req and mem_addr SHALL stay stable while mem_ready=0; mem_req=0 in IDLE.
REQ-026: Minimum miss penalty: 3 cycles from miss detection to hit=1 (FILL0, FILL1 with immediate mem_ready, then IDLE lookup).
REQ-027: redirect=1 has priority over stall and sequential advance: pc <= {redirect_pc[15:1],1'b0} next edge in every state.
REQ-028: redirect in FILL0: fill aborted, captured data discarded, line unchanged, state IDLE.
REQ-029: redirect in FILL1 with mem_ready=0: abort as REQ-028; with mem_ready=1: line write completes, then state IDLE at new pc.
REQ-030: stall SHALL NOT delay or abort a fill in progress.

Reset
REQ-031: rst_n=0 SHALL immediately force pc=RESET_PC, state IDLE, all valid bits 0, mem_req=0, mem_addr=0, hit=0.
REQ-032: Reset mid-fill SHALL abort the fill without writing the line; data/tag arrays need no reset.
REQ-033: First edge after rst_n deassert: miss on RESET_PC, fill begins.

Structure
REQ-034: Shared package mips_fetch_pkg holds the FSM state type, 16-bit word/address widths, and the line-pair type.
REQ-035: One sub-module icache_array SHALL hold tag/valid/data storage with asynchronous read and single-port synchronous line write; FSM and pc stay in inst_fetch_unit.

Verification
REQ-036: Reset, mem_ready=1 always, memory word[a]=a^16'hA5A5 -> mem_addr 0 then 1, hit=1 on 4th cycle with instruction=16'hA5A5, nextinstruction=16'hA5A4.
REQ-037: Cached pair at pc=4, stall=1 for 5 cycles -> pc stays 4, hit=1, outputs constant; stall=0 -> pc=6 next edge.
REQ-038: mem_ready low 3 cycles in FILL0 -> mem_req=1, mem_addr unchanged throughout, line filled correctly afterwards.
REQ-039: redirect_pc=16'h0031 during FILL0 -> pc=16'h0030, old line stays invalid, new fill to 16'h0030.
REQ-040: pc=16'hFFFE hit, no stall -> pc=16'h0000; re-fetch of 16'h0000 hits if still cached.
REQ-041: rst_n pulsed low during FILL1 -> mem_req=0 immediately, all lines invalid, pc=RESET_PC.
